// File: rtl/reaction_pkg.sv
// Shared constants and the LFSR step function for the reaction-time game timebase.
package reaction_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          MS_PER_S  = 1000;

    // One right-shifting Galois step: the bit shifted out decides whether the taps are applied.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        logic [15:0] shifted;
        shifted = state >> 1;
        return state[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock and only reset reseeds it.
module lfsr16
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] r_state;

    // Advance the sequence one step per clock.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LFSR_SEED;
        end else begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign q = r_state;

endmodule

// File: rtl/reaction_timebase.sv
// Timing and randomness source for the reaction-time game: ms prescaler, saturating
// up/down reaction timer, seconds countdown and a scaled random LED index.
module reaction_timebase
    import reaction_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int MAX_MS       = 2047,
    parameter int GAME_SECONDS = 10,
    parameter int LED_NUM      = 18,
    parameter int MIN_DELAY_MS = 500,
    localparam int MS_DIV      = CLK_HZ / 1000,
    localparam int TW          = $clog2(MAX_MS),
    localparam int GW          = $clog2(GAME_SECONDS + 1),
    localparam int RW          = $clog2(LED_NUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          timer_reset,
    input  logic          up,
    input  logic          enable,
    input  logic          game_reset,
    input  logic          game_timer_enable,
    output logic [TW-1:0] timer_value,
    output logic [GW-1:0] game_timer_value,
    output logic [RW-1:0] random_value,
    output logic          ms_tick
);

    localparam int MSW = (MS_DIV > 2) ? $clog2(MS_DIV) : 1;
    localparam int SCW = $clog2(MS_PER_S);

    localparam logic [MSW-1:0] MS_LAST  = MSW'(MS_DIV - 1);
    localparam logic [SCW-1:0] SEC_LAST = SCW'(MS_PER_S - 1);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(MAX_MS);

    logic [MSW-1:0] r_ms_cnt;
    logic           r_ms_tick;
    logic [TW-1:0]  r_timer;
    logic [SCW-1:0] r_sec_cnt;
    logic [GW-1:0]  r_game;
    logic [RW-1:0]  r_random;

    logic [15:0]    w_lfsr;
    logic [TW:0]    w_delay_sum;
    logic [TW-1:0]  w_delay_load;
    logic           w_sec_tick;
    logic [15:0]    w_scaled;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_lfsr)
    );

    // Random pre-LED delay, summed one bit wider than the timer so the clamp sees any overflow.
    assign w_delay_sum  = (TW + 1)'(MIN_DELAY_MS) + (TW + 1)'(w_lfsr[9:0]);
    assign w_delay_load = (w_delay_sum > (TW + 1)'(MAX_MS)) ? TIMER_MAX : w_delay_sum[TW-1:0];

    // A second elapses on the ms tick that completes a 1000-tick window.
    assign w_sec_tick = r_ms_tick && (r_sec_cnt == SEC_LAST);

    // Scaling the low byte by LED_NUM and keeping the top part maps 0..255 onto 0..LED_NUM-1.
    assign w_scaled = 16'(w_lfsr[7:0]) * 16'(LED_NUM);

    // Free-running ms prescaler; the tick is registered so it lands one cycle after the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_cnt  <= '0;
            r_ms_tick <= 1'b0;
        end else begin
            r_ms_tick <= (r_ms_cnt == MS_LAST);
            r_ms_cnt  <= (r_ms_cnt == MS_LAST) ? '0 : r_ms_cnt + MSW'(1);
        end
    end

    // Reaction timer: a load beats a coincident tick; counting saturates at both ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (timer_reset) begin
            r_timer <= up ? '0 : w_delay_load;
        end else if (enable && r_ms_tick) begin
            if (up) begin
                if (r_timer < TIMER_MAX) r_timer <= r_timer + TW'(1);
            end else begin
                if (r_timer != '0) r_timer <= r_timer - TW'(1);
            end
        end
    end

    // Game countdown: the ms-within-second counter only runs while the countdown is enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec_cnt <= '0;
            r_game    <= GW'(GAME_SECONDS);
        end else if (game_reset) begin
            r_sec_cnt <= '0;
            r_game    <= GW'(GAME_SECONDS);
        end else if (game_timer_enable && r_ms_tick) begin
            r_sec_cnt <= w_sec_tick ? '0 : r_sec_cnt + SCW'(1);
            if (w_sec_tick && (r_game != '0)) r_game <= r_game - GW'(1);
        end
    end

    // Register the scaled LED index every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_random <= '0;
        end else begin
            r_random <= w_scaled[8 +: RW];
        end
    end

    assign timer_value      = r_timer;
    assign game_timer_value = r_game;
    assign random_value     = r_random;
    assign ms_tick          = r_ms_tick;

endmodule
